// File: rtl/btn_cond_pkg.sv
// Shared defaults and counter-width helper for the button-conditioning front end.
package btn_cond_pkg;

  localparam int unsigned DEB_CYCLES_DEF  = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 100;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: two-flop synchroniser, debounce counter and long-hold detector.
module btn_chan
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int unsigned DW = cnt_width(DEB_CYCLES);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam logic [DW-1:0] DebLast = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
    end
  end

  // Debounce: any return of s2 to the current level discards accumulated credit.
  always_comb begin
    level_d = level_q;
    dcnt_d  = dcnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DebLast) begin
      level_d = s2_q;
      dcnt_d  = '0;
      press_d = s2_q;
      rel_d   = ~s2_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Hold: saturating counter so the pulse fires once per accepted press.
  always_comb begin
    hcnt_d = hcnt_q;
    hold_d = 1'b0;
    if (!level_q) begin
      hcnt_d = '0;
    end else if (hcnt_q < HoldMax) begin
      hcnt_d = hcnt_q + 1'b1;
      hold_d = (hcnt_q == HoldLast);
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign hold  = hold_q;

endmodule

// File: rtl/btn_cond.sv
// Button-conditioning front end: N_BTN independent debounced channels with
// press, release and long-hold pulses, all registered.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);

  for (genvar g = 0; g < N_BTN; g++) begin : gen_chan
    btn_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .press(btn_press[g]),
      .rel  (btn_release[g]),
      .hold (btn_hold[g])
    );
  end

endmodule
